ll_fifo_param: RTL and testbench

- Parametrised LocalLink (sof/eof/error/src_rdy/dst_rdy) buffering FIFO; generalises the fixed 8-bit, 11-bit-wide short FIFO to any payload width and power-of-two depth.
- Adds occupancy, free-space and stored-frame-count outputs.
- Optional store-and-forward packet mode.
- Sits between MAC rx/tx framers and the packet buffers, on a single clock domain.

---
 rtl/ll_pkg.sv | 51 +++++
 rtl/ll_fifo_mem.sv | 46 ++++
 rtl/ll_fifo_param.sv | 176 +++++++++++++++++
 tb/tb_ll_fifo_param.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ll_pkg.sv
// ---------------------------------------------------------------------------
// ll_pkg
// Shared LocalLink definitions for the buffering FIFO family.
//
// Contents:
//   LL_FLAG_W          number of frame flag bits stored next to each payload
//   LL_SOF/LL_EOF/LL_ERR
//                      flag bit offsets; the flags sit directly above the
//                      payload, so the absolute entry bit is WIDTH + offset
//   ll_flags_t         unpacked view of the flag field
//   ll_pack_flags      builds the flag field from individual flags
//   ll_unpack_flags    splits a stored flag field back into named flags
// ---------------------------------------------------------------------------
package ll_pkg;

    localparam int LL_FLAG_W = 3;

    localparam int LL_SOF = 0;
    localparam int LL_EOF = 1;
    localparam int LL_ERR = 2;

    typedef struct packed {
        logic error;
        logic eof;
        logic sof;
    } ll_flags_t;

    function automatic logic [LL_FLAG_W-1:0] ll_pack_flags(
        input logic sof,
        input logic eof,
        input logic error
    );
        logic [LL_FLAG_W-1:0] f;
        f         = '0;
        f[LL_SOF] = sof;
        f[LL_EOF] = eof;
        f[LL_ERR] = error;
        return f;
    endfunction

    function automatic ll_flags_t ll_unpack_flags(
        input logic [LL_FLAG_W-1:0] f
    );
        ll_flags_t u;
        u.sof   = f[LL_SOF];
        u.eof   = f[LL_EOF];
        u.error = f[LL_ERR];
        return u;
    endfunction

endpackage

// File: rtl/ll_fifo_mem.sv
// ---------------------------------------------------------------------------
// ll_fifo_mem
// Simple dual-port storage array: one registered write port, one
// asynchronous read port. Kept separate from the FIFO control so the array
// maps onto distributed/LUT RAM without control logic mixed in.
// Contents are never reset.
//
// Parameters:
//   WIDTH   bits per entry
//   ADDR_W  address bits; the array holds 2**ADDR_W entries
//
// Ports:
//   clk      in   write clock (rising edge)
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_addr  in   read address
//   rd_data  out  read data, combinational from rd_addr
// ---------------------------------------------------------------------------
module ll_fifo_mem
    import ll_pkg::*;
#(
    parameter int WIDTH  = 8 + LL_FLAG_W,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    localparam int ENTRIES = 1 << ADDR_W;

    logic [WIDTH-1:0] mem [0:ENTRIES-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ll_fifo_param.sv
// ---------------------------------------------------------------------------
// ll_fifo_param
// Parametrised LocalLink buffering FIFO (single clock domain). Each entry
// holds {error, eof, sof, data}; the head entry is shown combinationally
// (show-ahead). Also reports occupancy, free space and the number of
// complete frames (entries carrying eof) currently stored.
//
// Build option:
//   LL_FIFO_PKT_MODE_EN  when defined, store-and-forward: the head is only
//                        offered once at least one complete frame is stored.
//                        Undefined (default): cut-through.
//
// Parameters:
//   WIDTH       payload bits per beat
//   DEPTH_LOG2  log2 of entry count (1..10, i.e. 2..1024 entries)
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous active-high reset
//   clear      in   synchronous flush, same effect as reset on FIFO state
//   datain     in   write payload
//   sof_i      in   start-of-frame flag of write beat
//   eof_i      in   end-of-frame flag of write beat
//   error_i    in   frame error flag, meaningful with eof_i
//   src_rdy_i  in   upstream beat valid
//   dst_rdy_o  out  FIFO accepts a beat
//   dataout    out  head payload (show-ahead)
//   sof_o      out  head sof flag
//   eof_o      out  head eof flag
//   error_o    out  head error flag
//   src_rdy_o  out  head entry valid
//   dst_rdy_i  in   downstream accepts head beat
//   occupied   out  entries stored, 0..DEPTH
//   space      out  free entries, DEPTH - occupied
//   frames     out  complete frames stored
// ---------------------------------------------------------------------------
module ll_fifo_param
    import ll_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [WIDTH-1:0]      datain,
    input  logic                  sof_i,
    input  logic                  eof_i,
    input  logic                  error_i,
    input  logic                  src_rdy_i,
    output logic                  dst_rdy_o,
    output logic [WIDTH-1:0]      dataout,
    output logic                  sof_o,
    output logic                  eof_o,
    output logic                  error_o,
    output logic                  src_rdy_o,
    input  logic                  dst_rdy_i,
    output logic [DEPTH_LOG2:0]   occupied,
    output logic [DEPTH_LOG2:0]   space,
    output logic [DEPTH_LOG2:0]   frames
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int EW    = WIDTH + LL_FLAG_W;

    localparam logic [CW-1:0]         DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW-1:0]         CNT_ONE   = CW'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

    generate
        if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 10) begin : g_bad_depth
            $error("ll_fifo_param: DEPTH_LOG2 must be in 1..10");
        end
    endgenerate

    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [CW-1:0]         occ;
    logic [CW-1:0]         frm;

    logic                  full;
    logic                  empty;
    logic                  wr_fire;
    logic                  rd_fire;
    logic                  wr_eof;
    logic                  rd_eof;

    logic [EW-1:0]         wr_entry;
    logic [EW-1:0]         rd_entry;
    ll_flags_t             rd_flags;

    // Full/empty come from the registered count, so a read in the full
    // cycle cannot combinationally reopen the write side.
    assign full  = (occ == DEPTH_CNT);
    assign empty = (occ == '0);

    assign dst_rdy_o = !full && !reset && !clear;

`ifdef LL_FIFO_PKT_MODE_EN
    assign src_rdy_o = !empty && (frm != '0);
`else
    assign src_rdy_o = !empty;
`endif

    assign wr_fire = src_rdy_i && dst_rdy_o;
    assign rd_fire = src_rdy_o && dst_rdy_i;
    assign wr_eof  = wr_fire && eof_i;
    assign rd_eof  = rd_fire && eof_o;

    assign wr_entry = {ll_pack_flags(sof_i, eof_i, error_i), datain};

    ll_fifo_mem #(
        .WIDTH  (EW),
        .ADDR_W (DEPTH_LOG2)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_fire),
        .wr_addr (wr_ptr),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr),
        .rd_data (rd_entry)
    );

    assign rd_flags = ll_unpack_flags(rd_entry[EW-1:WIDTH]);
    assign dataout  = rd_entry[WIDTH-1:0];
    assign sof_o    = rd_flags.sof;
    assign eof_o    = rd_flags.eof;
    assign error_o  = rd_flags.error;

    assign occupied = occ;
    assign space    = DEPTH_CNT - occ;
    assign frames   = frm;

    // Pointer and counter state; reset/clear wins over any transfer.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
            frm    <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end

            case ({wr_fire, rd_fire})
                2'b10:   occ <= occ + CNT_ONE;
                2'b01:   occ <= occ - CNT_ONE;
                default: occ <= occ;
            endcase

            case ({wr_eof, rd_eof})
                2'b10:   frm <= frm + CNT_ONE;
                2'b01:   frm <= frm - CNT_ONE;
                default: frm <= frm;
            endcase
        end
    end

    a_frames_le_occ: assert property (
        @(posedge clk) disable iff (reset || clear) frm <= occ
    ) else $error("ll_fifo_param: frame count exceeds occupancy");

`ifdef LL_FIFO_PKT_MODE_EN
    // A full FIFO with no complete frame can never drain: the frame in
    // flight is longer than the buffer.
    a_pkt_no_deadlock: assert property (
        @(posedge clk) disable iff (reset || clear) !(full && frm == '0)
    ) else $error("ll_fifo_param: frame longer than DEPTH in packet mode");
`endif

endmodule

// File: tb/tb_ll_fifo_param.sv
module tb_ll_fifo_param;

    localparam int W  = 8;
    localparam int DL = 4;
    localparam int CW = DL + 1;
    localparam int DEPTH = 1 << DL;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1;
    logic          clear = 1'b0;
    logic [W-1:0]  datain = '0;
    logic          sof_i = 1'b0;
    logic          eof_i = 1'b0;
    logic          error_i = 1'b0;
    logic          src_rdy_i = 1'b0;
    logic          dst_rdy_i = 1'b0;
    logic          dst_rdy_o;
    logic [W-1:0]  dataout;
    logic          sof_o, eof_o, error_o, src_rdy_o;
    logic [CW-1:0] occupied, space, frames;

    int n_cmp = 0;
    int n_err = 0;

    ll_fifo_param #(.WIDTH(W), .DEPTH_LOG2(DL)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .datain    (datain),
        .sof_i     (sof_i),
        .eof_i     (eof_i),
        .error_i   (error_i),
        .src_rdy_i (src_rdy_i),
        .dst_rdy_o (dst_rdy_o),
        .dataout   (dataout),
        .sof_o     (sof_o),
        .eof_o     (eof_o),
        .error_o   (error_o),
        .src_rdy_o (src_rdy_o),
        .dst_rdy_i (dst_rdy_i),
        .occupied  (occupied),
        .space     (space),
        .frames    (frames)
    );

    typedef struct {
        logic       rs, cl;
        logic [7:0] d;
        logic       s, e, r, sv, dr;
        logic       c, cd;
        logic       xdst, xsrc;
        logic [7:0] xd;
        logic       xs, xe, xr;
        int         xo, xf;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(
        input logic rs, input logic cl, input logic [7:0] d,
        input logic s, input logic e, input logic r, input logic sv, input logic dr,
        input logic c, input logic cd, input logic xdst, input logic xsrc,
        input logic [7:0] xd, input logic xs, input logic xe, input logic xr,
        input int xo, input int xf
    );
        vec_t v;
        v.rs = rs; v.cl = cl; v.d = d; v.s = s; v.e = e; v.r = r;
        v.sv = sv; v.dr = dr; v.c = c; v.cd = cd; v.xdst = xdst; v.xsrc = xsrc;
        v.xd = xd; v.xs = xs; v.xe = xe; v.xr = xr; v.xo = xo; v.xf = xf;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1 time
    // unit before the next rising edge, i.e. the values the edge will see.
    task automatic drive(input logic rs, input logic cl, input logic [7:0] d,
                         input logic s, input logic e, input logic r,
                         input logic sv, input logic dr);
        @(negedge clk);
        reset = rs; clear = cl; datain = d;
        sof_i = s; eof_i = e; error_i = r;
        src_rdy_i = sv; dst_rdy_i = dr;
        #4;
    endtask

    task automatic idle(input logic dr);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, dr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
`ifndef LL_FIFO_PKT_MODE_EN
        // rs cl d s e r sv dr | c cd xdst xsrc xd xs xe xr xocc xfrm
        vt.push_back(mk(1,0,8'h00,0,0,0,0,0, 0,0, 0,0,8'h00,0,0,0, 0,0));
        vt.push_back(mk(0,0,8'h00,0,0,0,0,0, 1,0, 1,0,8'h00,0,0,0, 0,0));
        // frame 01..05, downstream stalled
        vt.push_back(mk(0,0,8'h01,1,0,0,1,0, 1,0, 1,0,8'h00,0,0,0, 0,0));
        vt.push_back(mk(0,0,8'h02,0,0,0,1,0, 1,1, 1,1,8'h01,1,0,0, 1,0));
        vt.push_back(mk(0,0,8'h03,0,0,0,1,0, 1,1, 1,1,8'h01,1,0,0, 2,0));
        vt.push_back(mk(0,0,8'h04,0,0,0,1,0, 1,1, 1,1,8'h01,1,0,0, 3,0));
        vt.push_back(mk(0,0,8'h05,0,1,0,1,0, 1,1, 1,1,8'h01,1,0,0, 4,0));
        vt.push_back(mk(0,0,8'h00,0,0,0,0,0, 1,1, 1,1,8'h01,1,0,0, 5,1));
        // drain it
        vt.push_back(mk(0,0,8'h00,0,0,0,0,1, 1,1, 1,1,8'h01,1,0,0, 5,1));
        vt.push_back(mk(0,0,8'h00,0,0,0,0,1, 1,1, 1,1,8'h02,0,0,0, 4,1));
        vt.push_back(mk(0,0,8'h00,0,0,0,0,1, 1,1, 1,1,8'h03,0,0,0, 3,1));
        vt.push_back(mk(0,0,8'h00,0,0,0,0,1, 1,1, 1,1,8'h04,0,0,0, 2,1));
        vt.push_back(mk(0,0,8'h00,0,0,0,0,1, 1,1, 1,1,8'h05,0,1,0, 1,1));
        vt.push_back(mk(0,0,8'h00,0,0,0,0,0, 1,0, 1,0,8'h00,0,0,0, 0,0));
        // single-beat frame with error
        vt.push_back(mk(0,0,8'hA5,1,1,1,1,0, 1,0, 1,0,8'h00,0,0,0, 0,0));
        vt.push_back(mk(0,0,8'h00,0,0,0,0,1, 1,1, 1,1,8'hA5,1,1,1, 1,1));
        vt.push_back(mk(0,0,8'h00,0,0,0,0,0, 1,0, 1,0,8'h00,0,0,0, 0,0));
        // one full frame + partial frame, then clear mid-frame
        vt.push_back(mk(0,0,8'h10,1,0,0,1,0, 1,0, 1,0,8'h00,0,0,0, 0,0));
        vt.push_back(mk(0,0,8'h11,0,0,0,1,0, 1,1, 1,1,8'h10,1,0,0, 1,0));
        vt.push_back(mk(0,0,8'h12,0,1,0,1,0, 1,1, 1,1,8'h10,1,0,0, 2,0));
        vt.push_back(mk(0,0,8'h20,1,0,0,1,0, 1,1, 1,1,8'h10,1,0,0, 3,1));
        vt.push_back(mk(0,0,8'h21,0,0,0,1,0, 1,1, 1,1,8'h10,1,0,0, 4,1));
        vt.push_back(mk(0,0,8'h22,0,0,0,1,0, 1,1, 1,1,8'h10,1,0,0, 5,1));
        vt.push_back(mk(0,0,8'h23,0,0,0,1,0, 1,1, 1,1,8'h10,1,0,0, 6,1));
        vt.push_back(mk(0,1,8'h24,0,0,0,1,0, 1,1, 0,1,8'h10,1,0,0, 7,1));
        vt.push_back(mk(0,0,8'h00,0,0,0,0,1, 1,0, 1,0,8'h00,0,0,0, 0,0));
        // fresh frame after clear
        vt.push_back(mk(0,0,8'h30,1,0,0,1,0, 1,0, 1,0,8'h00,0,0,0, 0,0));
        vt.push_back(mk(0,0,8'h31,0,0,0,1,0, 1,1, 1,1,8'h30,1,0,0, 1,0));
        vt.push_back(mk(0,0,8'h32,0,1,0,1,0, 1,1, 1,1,8'h30,1,0,0, 2,0));
        vt.push_back(mk(0,0,8'h00,0,0,0,0,1, 1,1, 1,1,8'h30,1,0,0, 3,1));
        vt.push_back(mk(0,0,8'h00,0,0,0,0,1, 1,1, 1,1,8'h31,0,0,0, 2,1));
        vt.push_back(mk(0,0,8'h00,0,0,0,0,1, 1,1, 1,1,8'h32,0,1,0, 1,1));
        vt.push_back(mk(0,0,8'h00,0,0,0,0,0, 1,0, 1,0,8'h00,0,0,0, 0,0));

        foreach (vt[k]) begin
            drive(vt[k].rs, vt[k].cl, vt[k].d, vt[k].s, vt[k].e, vt[k].r, vt[k].sv, vt[k].dr);
            if (vt[k].c) begin
                chk($sformatf("v%0d_dst_rdy", k), 32'(dst_rdy_o), 32'(vt[k].xdst));
                chk($sformatf("v%0d_src_rdy", k), 32'(src_rdy_o), 32'(vt[k].xsrc));
                chk($sformatf("v%0d_occupied", k), 32'(occupied), vt[k].xo);
                chk($sformatf("v%0d_space", k), 32'(space), DEPTH - vt[k].xo);
                chk($sformatf("v%0d_frames", k), 32'(frames), vt[k].xf);
                if (vt[k].cd) begin
                    chk($sformatf("v%0d_dataout", k), 32'(dataout), 32'(vt[k].xd));
                    chk($sformatf("v%0d_sof", k), 32'(sof_o), 32'(vt[k].xs));
                    chk($sformatf("v%0d_eof", k), 32'(eof_o), 32'(vt[k].xe));
                    chk($sformatf("v%0d_err", k), 32'(error_o), 32'(vt[k].xr));
                end
            end
        end

        // Fill to full, then read one with the writer still pushing.
        drive(1, 0, 8'h00, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 8'(8'h40 + i), i == 0, (i % 4) == 3, 0, 1, 0);
            chk($sformatf("fill%0d_dst_rdy", i), 32'(dst_rdy_o), 32'd1);
        end
        idle(0);
        chk("full_dst_rdy", 32'(dst_rdy_o), 32'd0);
        chk("full_occupied", 32'(occupied), 32'd16);
        chk("full_space", 32'(space), 32'd0);
        chk("full_frames", 32'(frames), 32'd4);
        drive(0, 0, 8'h99, 0, 1, 0, 1, 1);
        chk("full_rd_no_open", 32'(dst_rdy_o), 32'd0);
        chk("full_rd_head", 32'(dataout), 32'h40);
        drive(0, 0, 8'h99, 0, 1, 0, 1, 0);
        chk("reopen_dst_rdy", 32'(dst_rdy_o), 32'd1);
        chk("reopen_occupied", 32'(occupied), 32'd15);
        idle(0);
        chk("refill_occupied", 32'(occupied), 32'd16);
        chk("refill_frames", 32'(frames), 32'd5);
        for (int i = 0; i < 16; i++) begin
            idle(1);
            chk($sformatf("drain%0d_src_rdy", i), 32'(src_rdy_o), 32'd1);
            chk($sformatf("drain%0d_data", i), 32'(dataout),
                (i < 15) ? 32'(8'h41 + i) : 32'h99);
        end
        idle(0);
        chk("drained_occupied", 32'(occupied), 32'd0);
        chk("drained_frames", 32'(frames), 32'd0);

        // Full-rate streaming at constant occupancy 3 across many wraps.
        drive(1, 0, 8'h00, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 8'(i), 0, 0, 0, 1, 0);
        for (int i = 0; i < 100; i++) begin
            drive(0, 0, 8'(3 + i), 0, 0, 0, 1, 1);
            chk($sformatf("stream%0d_occ", i), 32'(occupied), 32'd3);
            chk($sformatf("stream%0d_data", i), 32'(dataout), 32'(8'(i)));
        end
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk($sformatf("tail%0d_data", i), 32'(dataout), 32'(100 + i));
        end
        idle(0);
        chk("stream_end_src_rdy", 32'(src_rdy_o), 32'd0);
        chk("stream_end_occ", 32'(occupied), 32'd0);
`else
        // Store-and-forward: nothing offered until the eof beat is stored.
        drive(1, 0, 8'h00, 0, 0, 0, 0, 0);
        idle(0);
        chk("pkt_reset_occ", 32'(occupied), 32'd0);
        chk("pkt_reset_dst_rdy", 32'(dst_rdy_o), 32'd1);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 8'(8'h61 + i), i == 0, 0, 0, 1, 1);
            chk($sformatf("pkt_w%0d_src_rdy", i), 32'(src_rdy_o), 32'd0);
        end
        drive(0, 0, 8'h65, 0, 1, 0, 1, 1);
        chk("pkt_eofw_src_rdy", 32'(src_rdy_o), 32'd0);
        chk("pkt_eofw_occ", 32'(occupied), 32'd4);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            chk($sformatf("pkt_r%0d_src_rdy", i), 32'(src_rdy_o), 32'd1);
            chk($sformatf("pkt_r%0d_data", i), 32'(dataout), 32'(8'h61 + i));
            chk($sformatf("pkt_r%0d_eof", i), 32'(eof_o), (i == 4) ? 32'd1 : 32'd0);
        end
        idle(1);
        chk("pkt_end_src_rdy", 32'(src_rdy_o), 32'd0);
        chk("pkt_end_frames", 32'(frames), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
